// File: rtl/mem_access_multi.sv
// Memory access sequencer for the multicycle core.
// One memory transaction per control-FSM request, with fault reporting.
module mem_access_multi #(
    parameter int TIMEOUT = 255
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic        iIouD,
    input  logic [31:0] iPC,
    input  logic [31:0] iALUOut,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iStoreData,
    output logic [31:0] oMemAddr,
    output logic        oMemRE,
    output logic        oMemWE,
    output logic [3:0]  oMemBE,
    output logic [31:0] oMemWData,
    input  logic [31:0] iMemRData,
    input  logic        iMemReady,
    output logic [31:0] oMDR,
    output logic        oBusy,
    output logic        oDone,
    output logic        oFault,
    output logic [1:0]  oFaultCode
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_ALIGN = 2'b01;
    localparam logic [1:0] FC_ILL   = 2'b10;
    localparam logic [1:0] FC_TOUT  = 2'b11;

    // Counter value on the last permitted cycle without ready.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic        wr_q, wr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mdr_q, mdr_d;
    logic [1:0]  code_q, code_d;

    logic        req;
    logic [31:0] req_addr;
    logic [1:0]  dec_size;
    logic        dec_sext;
    logic        dec_ill;
    logic        dec_mis;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;
    logic [31:0] lane;
    logic [31:0] load_ext;

    assign req      = iMemRead | iMemWrite;
    assign req_addr = iIouD ? iALUOut : iPC;

    // Decode size/sign/legality of the incoming request.
    always_comb begin
        dec_size = SZ_WORD;
        dec_sext = 1'b0;
        dec_ill  = 1'b0;
        if (iMemRead && iMemWrite) begin
            dec_ill = 1'b1;
        end else if (iIouD) begin
            if (iMemRead) begin
                case (iFunct3)
                    3'b000: begin dec_size = SZ_BYTE; dec_sext = 1'b1; end
                    3'b001: begin dec_size = SZ_HALF; dec_sext = 1'b1; end
                    3'b010: dec_size = SZ_WORD;
                    3'b100: dec_size = SZ_BYTE;
                    3'b101: dec_size = SZ_HALF;
                    default: dec_ill = 1'b1;
                endcase
            end else begin
                case (iFunct3)
                    3'b000: dec_size = SZ_BYTE;
                    3'b001: dec_size = SZ_HALF;
                    3'b010: dec_size = SZ_WORD;
                    default: dec_ill = 1'b1;
                endcase
            end
        end
    end

    // Alignment check, byte enables and lane-replicated store data.
    always_comb begin
        dec_mis   = 1'b0;
        dec_be    = 4'hF;
        dec_wdata = iStoreData;
        unique case (dec_size)
            SZ_BYTE: begin
                dec_be    = 4'b0001 << req_addr[1:0];
                dec_wdata = {4{iStoreData[7:0]}};
            end
            SZ_HALF: begin
                dec_mis   = req_addr[0];
                dec_be    = 4'b0011 << {req_addr[1], 1'b0};
                dec_wdata = {2{iStoreData[15:0]}};
            end
            default: begin
                dec_mis   = (req_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Select and extend the addressed lane of the read data.
    always_comb begin
        lane     = iMemRData >> {addr_q[1:0], 3'b000};
        load_ext = lane;
        unique case (size_q)
            SZ_BYTE: load_ext = {{24{sext_q & lane[7]}}, lane[7:0]};
            SZ_HALF: load_ext = {{16{sext_q & lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Next-state logic: accept, wait for ready or timeout, report.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        sext_d  = sext_q;
        wr_d    = wr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        mdr_d   = mdr_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = req_addr;
                    size_d  = dec_size;
                    sext_d  = dec_sext;
                    wr_d    = iMemWrite;
                    be_d    = dec_be;
                    wdata_d = dec_wdata;
                    cnt_d   = 16'd0;
                    if (dec_ill) begin
                        code_d  = FC_ILL;
                        state_d = FAULT;
                    end else if (dec_mis) begin
                        code_d  = FC_ALIGN;
                        state_d = FAULT;
                    end else begin
                        code_d  = FC_NONE;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (iMemReady) begin
                    if (!wr_q) mdr_d = load_ext;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    code_d  = FC_TOUT;
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            addr_q  <= 32'd0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            mdr_q   <= 32'd0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            mdr_q   <= mdr_d;
            code_q  <= code_d;
        end
    end

    assign oMemAddr   = {addr_q[31:2], 2'b00};
    assign oMemRE     = (state_q == ACCESS) && !wr_q;
    assign oMemWE     = (state_q == ACCESS) && wr_q;
    assign oMemBE     = be_q;
    assign oMemWData  = wdata_q;
    assign oMDR       = mdr_q;
    assign oBusy      = (state_q == ACCESS);
    assign oDone      = (state_q == DONE) || (state_q == FAULT);
    assign oFault     = (state_q == FAULT);
    assign oFaultCode = code_q;

endmodule

// File: tb/tb_mem_access_multi.sv
// Scoreboard bench for mem_access_multi.
// Random and directed requests against a behavioural memory model.
module tb_mem_access_multi;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iMemRead = 1'b0, iMemWrite = 1'b0, iIouD = 1'b0;
    logic [31:0] iPC = '0, iALUOut = '0, iStoreData = '0;
    logic [2:0]  iFunct3 = '0;
    logic [31:0] oMemAddr, oMemWData, oMDR;
    logic        oMemRE, oMemWE, oBusy, oDone, oFault;
    logic [3:0]  oMemBE;
    logic [1:0]  oFaultCode;
    logic [31:0] iMemRData = '0;
    logic        iMemReady = 1'b0;

    mem_access_multi #(.TIMEOUT(TO)) dut (
        .iCLK(clk), .iRST_N(rst_n),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iIouD(iIouD),
        .iPC(iPC), .iALUOut(iALUOut), .iFunct3(iFunct3),
        .iStoreData(iStoreData),
        .oMemAddr(oMemAddr), .oMemRE(oMemRE), .oMemWE(oMemWE),
        .oMemBE(oMemBE), .oMemWData(oMemWData),
        .iMemRData(iMemRData), .iMemReady(iMemReady),
        .oMDR(oMDR), .oBusy(oBusy), .oDone(oDone),
        .oFault(oFault), .oFaultCode(oFaultCode)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
        bit          stall;
        bit          fault;
        logic [1:0]  code;
        logic [31:0] mdr;
        int          cycles;
        int          lat;
        int          req_cyc;
    } item_t;

    item_t       sb[$];
    logic [31:0] mem [64];
    logic [31:0] exp_mdr = '0;
    int n_vec = 0, n_bad = 0;
    int cyc = 0, strobe_cnt = 0, wait_cnt = 0, done_cnt = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: expected response from the access rules.
    function automatic item_t model(bit rd, bit wr, bit iouD,
                                    logic [31:0] pc, logic [31:0] alu,
                                    logic [2:0] f3, logic [31:0] sd,
                                    int delay, bit stall);
        item_t it;
        int nb, off;
        bit sg, bad;
        logic [31:0] v, mask;
        it.rd = rd; it.wr = wr; it.delay = delay; it.stall = stall;
        it.addr = iouD ? alu : pc;
        it.req_cyc = 0;
        nb = 4; sg = 0; bad = 0;
        if (rd && wr) bad = 1;
        else if (iouD && rd) begin
            case (f3)
                3'd0: begin nb = 1; sg = 1; end
                3'd1: begin nb = 2; sg = 1; end
                3'd2: nb = 4;
                3'd4: nb = 1;
                3'd5: nb = 2;
                default: bad = 1;
            endcase
        end else if (iouD) begin
            case (f3)
                3'd0: nb = 1;
                3'd1: nb = 2;
                3'd2: nb = 4;
                default: bad = 1;
            endcase
        end
        off = int'(it.addr[1:0]);
        it.be = 4'(((1 << nb) - 1) << off);
        it.wdata = (nb == 1) ? {4{sd[7:0]}} : (nb == 2) ? {2{sd[15:0]}} : sd;
        it.fault = 1; it.cycles = 0; it.lat = 1; it.mdr = exp_mdr;
        if (bad) it.code = 2'b10;
        else if (off % nb != 0) it.code = 2'b01;
        else if (stall) begin
            it.code = 2'b11; it.cycles = TO; it.lat = TO + 1;
        end else begin
            it.fault = 0; it.code = 2'b00;
            it.cycles = delay + 1; it.lat = delay + 2;
            if (rd) begin
                mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 1;
                v = (mem[it.addr[7:2]] >> (8 * off)) & mask;
                if (sg && v[8 * nb - 1]) v = v | ~mask;
                exp_mdr = v;
                it.mdr = v;
            end
        end
        return it;
    endfunction

    // Memory responder: checks the bus and answers after the chosen delay.
    always @(negedge clk) begin
        if (!rst_n) begin
            iMemReady = 1'b0;
            wait_cnt = 0;
        end else if (oMemRE || oMemWE) begin
            if (sb.size() == 0) begin
                chk("strobe_unexpected", 32'(oMemRE | oMemWE), 32'd0);
                iMemReady = 1'b1;
            end else begin
                if (wait_cnt == 0) begin
                    chk("mem_re", 32'(oMemRE), 32'(sb[0].rd));
                    chk("mem_we", 32'(oMemWE), 32'(sb[0].wr));
                    chk("mem_addr", oMemAddr, {sb[0].addr[31:2], 2'b00});
                    chk("mem_be", 32'(oMemBE), 32'(sb[0].be));
                    if (sb[0].wr) chk("mem_wdata", oMemWData, sb[0].wdata);
                end
                chk("busy", 32'(oBusy), 32'd1);
                strobe_cnt++;
                if (!sb[0].stall && wait_cnt == sb[0].delay) begin
                    iMemReady = 1'b1;
                    iMemRData = mem[oMemAddr[7:2]];
                    if (oMemWE)
                        for (int b = 0; b < 4; b++)
                            if (oMemBE[b])
                                mem[oMemAddr[7:2]][8*b +: 8] = oMemWData[8*b +: 8];
                end else begin
                    iMemReady = 1'b0;
                    iMemRData = $urandom;
                end
                wait_cnt++;
            end
        end else begin
            iMemReady = 1'($urandom_range(0, 1));
            iMemRData = $urandom;
            wait_cnt = 0;
        end
    end

    // Monitor: pop the expected response whenever oDone is seen.
    always @(negedge clk) begin
        if (rst_n) begin
            if (oFault && !oDone) chk("fault_without_done", 32'd1, 32'd0);
            if (oDone) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    item_t it;
                    it = sb.pop_front();
                    chk("fault", 32'(oFault), 32'(it.fault));
                    chk("fault_code", 32'(oFaultCode), 32'(it.code));
                    chk("mdr", oMDR, it.mdr);
                    chk("strobe_cycles", 32'(strobe_cnt), 32'(it.cycles));
                    chk("latency", 32'(cyc - it.req_cyc), 32'(it.lat));
                    chk("busy_at_done", 32'(oBusy), 32'd0);
                end
                strobe_cnt = 0;
                done_cnt++;
            end
        end
    end

    task automatic issue(bit rd, bit wr, bit iouD, logic [31:0] pc,
                         logic [31:0] alu, logic [2:0] f3,
                         logic [31:0] sd, int delay, bit stall);
        item_t it;
        it = model(rd, wr, iouD, pc, alu, f3, sd, delay, stall);
        it.req_cyc = cyc;
        sb.push_back(it);
        iMemRead = rd; iMemWrite = wr; iIouD = iouD;
        iPC = pc; iALUOut = alu; iFunct3 = f3; iStoreData = sd;
        @(posedge clk);
        #1;
        iMemRead = 1'($urandom_range(0, 1));
        iMemWrite = 1'($urandom_range(0, 1));
        iPC = $urandom; iALUOut = $urandom; iFunct3 = 3'($urandom);
        iStoreData = $urandom;
    endtask

    task automatic do_req(bit rd, bit wr, bit iouD, logic [31:0] pc,
                          logic [31:0] alu, logic [2:0] f3,
                          logic [31:0] sd, int delay, bit stall);
        int start;
        start = done_cnt;
        issue(rd, wr, iouD, pc, alu, f3, sd, delay, stall);
        for (int k = 0; k < 60 && done_cnt == start; k++) @(negedge clk);
        if (done_cnt == start) begin
            chk("done_wait_expired", 32'd0, 32'd1);
            sb.delete();
        end
        iMemRead = 1'b0; iMemWrite = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, p;
        int r;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_re", 32'(oMemRE), 32'd0);
        chk("rst_we", 32'(oMemWE), 32'd0);
        chk("rst_be", 32'(oMemBE), 32'd0);
        chk("rst_addr", oMemAddr, 32'd0);
        chk("rst_wdata", oMemWData, 32'd0);
        chk("rst_mdr", oMDR, 32'd0);
        chk("rst_flags", 32'({oBusy, oDone, oFault, oFaultCode}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        mem[16] = 32'h00A00093;
        do_req(1, 0, 0, 32'h40, 32'h123, 3'b111, 32'h0, 0, 0);
        mem[0] = 32'h80123456;
        do_req(1, 0, 1, 32'h0, 32'h103, 3'b000, 32'h0, 0, 0);
        do_req(1, 0, 1, 32'h0, 32'h103, 3'b100, 32'h0, 1, 0);
        do_req(0, 1, 1, 32'h0, 32'h202, 3'b001, 32'hDEAD1234, 2, 0);
        do_req(1, 0, 1, 32'h0, 32'h202, 3'b010, 32'h0, 0, 0);
        do_req(1, 0, 1, 32'h0, 32'h200, 3'b010, 32'h0, 0, 0);
        do_req(1, 0, 1, 32'h0, 32'h101, 3'b010, 32'h0, 0, 0);
        do_req(1, 0, 1, 32'h0, 32'h100, 3'b011, 32'h0, 0, 0);
        do_req(1, 1, 1, 32'h0, 32'h100, 3'b010, 32'h0, 0, 0);
        do_req(0, 1, 1, 32'h0, 32'h100, 3'b100, 32'h0, 0, 0);
        do_req(1, 0, 1, 32'h0, 32'h1FC, 3'b010, 32'h0, 0, 1);

        issue(1, 0, 1, 32'h0, 32'h3C, 3'b010, 32'h0, 0, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_re", 32'(oMemRE), 32'd0);
        chk("midrst_busy", 32'(oBusy), 32'd0);
        chk("midrst_mdr", oMDR, 32'd0);
        chk("midrst_code", 32'(oFaultCode), 32'd0);
        sb.delete();
        strobe_cnt = 0;
        exp_mdr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        iMemRead = 1'b0; iMemWrite = 1'b0;
        @(negedge clk);
        do_req(1, 0, 1, 32'h0, 32'h3C, 3'b010, 32'h0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 19);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[0] = 1'b0;
            if ($urandom_range(0, 1) == 1) a[1] = 1'b0;
            p = $urandom;
            if ($urandom_range(0, 7) != 0) p[1:0] = 2'b00;
            do_req(r == 0 || r < 11, r == 0 || r >= 11,
                   1'($urandom_range(0, 3) != 0), p, a,
                   3'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_multi.md
Name: mem_access_multi

Overview:
- Memory access sequencer between the multicycle control FSM and the unified instruction/data memory.
- Receives the control FSM's read/write strobes and performs one memory transaction per request:
  - selects the address from PC or ALUOut (IouD), checks alignment;
  - generates byte enables and replicated store data;
  - waits for memory ready (bounded by a timeout);
  - sign/zero-extends load data into the MDR.
- Signals completion to the control FSM with a single-cycle done pulse.

Parameters:
TIMEOUT, 255, max cycles waiting for iMemReady before aborting (1..65535)

Ports:
iCLK  in  1  clock, all logic on rising edge
iRST_N  in  1  synchronous active-low reset
iMemRead  in  1  read request from control FSM
iMemWrite  in  1  write request from control FSM
iIouD  in  1  0: address=iPC (instruction fetch), 1: address=iALUOut (data)
iPC  in  32  program counter
iALUOut  in  32  data address register
iFunct3  in  3  load/store size/sign code
iStoreData  in  32  rs2 value for stores
oMemAddr  out  32  word-aligned address {addr[31:2],2'b00}
oMemRE  out  1  memory read strobe
oMemWE  out  1  memory write strobe
oMemBE  out  4  byte enables
oMemWData  out  32  store data, replicated by size
iMemRData  in  32  memory read data, valid when iMemReady=1
iMemReady  in  1  memory completes current access
oMDR  out  32  extended load/instruction data register
oBusy  out  1  transaction in progress
oDone  out  1  one-cycle completion pulse
oFault  out  1  one-cycle pulse with oDone on misaligned/illegal/timeout
oFaultCode  out  2  01 misaligned, 10 illegal funct3/both strobes, 11 timeout; holds until next accepted request

Behaviour:
- Reset (iRST_N=0 at edge, also mid-transaction):
  - state IDLE; timeout counter 0.
  - all outputs 0: oMemRE, oMemWE, oMemBE, oMemAddr, oMemWData, oMDR, oBusy, oDone, oFault, oFaultCode.
  - Any in-flight access is abandoned; strobes drop in the same edge.
- States: IDLE, ACCESS, DONE, FAULT.
- IDLE: request = iMemRead|iMemWrite. On request, latch address, iFunct3, iStoreData, direction, then:
  - both strobes high -> FAULT, code 10.
  - iIouD=0 -> access size forced to word, unsigned; iFunct3 ignored.
  - Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Any other value -> FAULT, code 10.
  - Store funct3: 000 SB, 001 SH, 010 SW. Any other value -> FAULT, code 10.
  - Misaligned -> FAULT, code 01. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Otherwise -> ACCESS; oBusy=1 from the next cycle.
  - Inputs are ignored while not IDLE.
- ACCESS:
  - oMemRE or oMemWE held high; oMemAddr, oMemBE and oMemWData stable.
  - oMemBE: byte = 0001<<addr[1:0]; half = 0011<<{addr[1],1'b0}; word = 1111. Reads drive the same BE.
  - oMemWData: byte = {4{d[7:0]}}, half = {2{d[15:0]}}, word = d.
  - Exit when iMemReady=1: strobes drop next cycle, -> DONE. For reads, oMDR captures the extended lane on that same edge.
    - Lane = iMemRData byte/half at addr[1:0].
    - LB/LH sign-extend; LBU/LHU/LW/fetch zero-fill/none.
  - Timeout: counter increments each ACCESS cycle without ready. When it reaches TIMEOUT, strobes drop -> FAULT, code 11. oMDR is unchanged.
- DONE: oDone=1 for one cycle, oBusy=0, -> IDLE.
  - Latency: ready on the first ACCESS cycle gives oDone 2 cycles after the request edge.
  - A request present during DONE is not accepted until IDLE.
- FAULT: oDone=1 and oFault=1 for one cycle, no memory strobe ever asserted, -> IDLE.
- oMDR changes only on successful reads; writes and faults leave it unchanged.
- No back-to-back acceptance: minimum 3 cycles per transaction.

Test Plan:
1. Fetch: iMemRead=1, iIouD=0, iPC=0x00000040, iFunct3=3'b111, ready on first ACCESS cycle, iMemRData=0x00A00093 -> oMemAddr=0x40, oMemBE=1111, oMDR=0x00A00093, oDone 2 cycles after request, oFault=0.
2. LB/LBU: iALUOut=0x103, iMemRData=0x80123456, LB -> oMemBE=1000, oMDR=0xFFFFFF80; repeat as LBU -> oMDR=0x00000080.
3. SH: iALUOut=0x202, iStoreData=0xDEAD1234, funct3=001 -> oMemAddr=0x200, oMemBE=1100, oMemWData=0x12341234, oMemWE high until ready, oMDR unchanged.
4. Faults:
   - LW at 0x101 -> oFault+oDone pulse, code 01, oMemRE never high.
   - Load funct3=011 -> code 10.
   - iMemRead=iMemWrite=1 -> code 10.
5. Timeout with TIMEOUT=4 and iMemReady held 0 -> oMemRE high exactly 4 cycles, then oFault with code 11, oMDR unchanged.
6. Reset mid-ACCESS: assert iRST_N=0 while waiting on ready -> next edge strobes/oBusy=0, oMDR=0. Release reset, issue a new LW -> completes normally.
